// File: rtl/fifo_uart_tx.sv
// Serial transmitter draining a show-ahead FIFO: start bit, DBIT data bits LSB first,
// optional parity bit, then one or two stop bits; one FIFO word per frame.
module fifo_uart_tx #(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd_en,
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT * 2);
  localparam int IW = $clog2(DBIT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DBIT - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  // IDLE: wait/pop | START: low bit | DATA: LSB first | PARITY: optional | STOP: high bits
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t          state, state_n;
  logic [DBIT-1:0] shift, shift_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic            par_bit, par_n;
  logic            tx_n;
  logic            bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    cnt_n      = bit_end ? '0 : cnt + CW'(1);
    idx_n      = idx;
    par_n      = par_bit;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n      = '0;
        fifo_rd_en = tx_en & ~fifo_empty & ~rst;
        if (fifo_rd_en) begin
          shift_n = fifo_rd_data;
          idx_n   = '0;
          // parity is latched from the word as popped, before any shifting
          par_n   = (PARITY == 2) ? ~^fifo_rd_data : ^fifo_rd_data;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx == STOP_LAST) begin
            frame_done = 1'b1;
            idx_n      = '0;
            state_n    = S_IDLE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // tx is registered, so it is derived from the state being entered
  always_comb begin
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shift_n[0];
      S_PARITY: tx_n = par_n;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      cnt     <= '0;
      idx     <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      par_bit <= par_n;
      tx      <= tx_n;
    end
  end

endmodule
